// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle MIPS control unit.
// The slave modport belongs to the controller; the master modport belongs to the datapath.
interface mips_multicycle_ctrl_if;
   logic [5:0] op;
   logic       zero;
   logic       memready;
   logic       memtoreg;
   logic       regdst;
   logic       iord;
   logic       alusrca;
   logic       irwrite;
   logic       memwrite;
   logic       pcwrite;
   logic       branch;
   logic       regwrite;
   logic       pcen;
   logic       illegal;
   logic [1:0] pcsrc;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [3:0] state;

   modport master (
      output op, zero, memready,
      input  memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite, branch,
      input  regwrite, pcen, illegal, pcsrc, alusrcb, aluop, state
   );

   modport slave (
      input  op, zero, memready,
      output memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite, branch,
      output regwrite, pcen, illegal, pcsrc, alusrcb, aluop, state
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j)
// with a memready handshake on instruction fetch and data accesses.
module mips_multicycle_ctrl (
   input logic                   clk,
   input logic                   reset,
   mips_multicycle_ctrl_if.slave bus
);

   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpRt   = 6'b000000;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpJ    = 6'b000010;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRtypeEx = 4'd6,
      StRtypeWb = 4'd7,
      StBeqEx   = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJex     = 4'd11
   } state_e;

   state_e state_q, state_d;

   logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite;
   logic       pcwrite, branch, regwrite, illegal;
   logic [1:0] pcsrc, alusrcb, aluop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = StFetch;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      pcsrc    = 2'b00;
      alusrcb  = 2'b00;
      aluop    = 2'b00;

      case (state_q)
         StFetch: begin
            // PC+4 and IR load only land on the cycle memory delivers the word
            alusrcb = 2'b01;
            irwrite = bus.memready;
            pcwrite = bus.memready;
            state_d = bus.memready ? StDecode : StFetch;
         end
         StDecode: begin
            alusrcb = 2'b11;
            case (bus.op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRt:       state_d = StRtypeEx;
               OpBeq:      state_d = StBeqEx;
               OpAddi:     state_d = StAddiEx;
               OpJ:        state_d = StJex;
               default: begin
                  illegal = 1'b1;
                  state_d = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            if (bus.op == OpLw) begin
               state_d = StMemRd;
            end else if (bus.op == OpSw) begin
               state_d = StMemWr;
            end else begin
               state_d = StFetch;
            end
         end
         StMemRd: begin
            iord    = 1'b1;
            state_d = bus.memready ? StMemWb : StMemRd;
         end
         StMemWb: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            state_d  = StFetch;
         end
         StMemWr: begin
            // Strobe stays up through the accepting cycle
            iord     = 1'b1;
            memwrite = 1'b1;
            state_d  = bus.memready ? StFetch : StMemWr;
         end
         StRtypeEx: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = StRtypeWb;
         end
         StRtypeWb: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_d  = StFetch;
         end
         StBeqEx: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
            state_d = StFetch;
         end
         StAddiEx: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = StAddiWb;
         end
         StAddiWb: begin
            regwrite = 1'b1;
            state_d  = StFetch;
         end
         StJex: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
            state_d = StFetch;
         end
         default: state_d = StFetch;
      endcase
   end

   assign bus.memtoreg = memtoreg;
   assign bus.regdst   = regdst;
   assign bus.iord     = iord;
   assign bus.alusrca  = alusrca;
   assign bus.irwrite  = irwrite;
   assign bus.memwrite = memwrite;
   assign bus.pcwrite  = pcwrite;
   assign bus.branch   = branch;
   assign bus.regwrite = regwrite;
   assign bus.illegal  = illegal;
   assign bus.pcsrc    = pcsrc;
   assign bus.alusrcb  = alusrcb;
   assign bus.aluop    = aluop;
   assign bus.pcen     = pcwrite | (branch & bus.zero);
   assign bus.state    = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
REQ-004 op  input  6  instruction opcode field from the instruction register.
REQ-005 zero  input  1  ALU zero flag, used only for branch resolution.
REQ-006 memready  input  1  memory handshake; access completes in a cycle with memready=1.
REQ-007 Single-bit outputs: memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite, branch, regwrite, pcen, illegal.
REQ-008 Two-bit outputs: pcsrc, alusrcb, aluop; aluop feeds the existing ALU decoder (00 add, 01 sub, 10 use funct).
REQ-009 state  output  4  current state, for debug and verification.

Function
REQ-010 Moore FSM, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-011 Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-012 FETCH: stay while memready=0; to DECODE when memready=1.
REQ-013 DECODE: lw/sw -> MEMADR; R-type -> RTYPEEX; beq -> BEQEX; addi -> ADDIEX; j -> JEX; any other op -> FETCH with illegal=1 for that DECODE cycle.
REQ-014 MEMADR: lw -> MEMRD; sw -> MEMWR; op re-sampled here (IR is stable).
REQ-015 MEMRD: stay while memready=0; to MEMWB on memready=1. MEMWR: same rule, to FETCH.
REQ-016 RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB; MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
REQ-017 Unused encodings 12-15 SHALL go to FETCH next cycle with all control outputs 0.
REQ-018 Every output not listed for a state SHALL be 0.
REQ-019 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=memready, pcwrite=memready.
REQ-020 DECODE: alusrca=0, alusrcb=11, aluop=00.
REQ-021 MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-022 MEMRD: iord=1. MEMWR: iord=1, memwrite=1 held every cycle until and including the memready=1 cycle.
REQ-023 MEMWB: regdst=0, memtoreg=1, regwrite=1. ADDIWB: regdst=0, memtoreg=0, regwrite=1. RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
REQ-024 RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
REQ-025 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
REQ-026 JEX: pcsrc=10, pcwrite=1.
REQ-027 pcen SHALL be combinational: pcwrite OR (branch AND zero), same cycle.
REQ-028 Only pcen, irwrite, pcwrite and illegal depend on inputs within a cycle; all other outputs SHALL be pure functions of state.
REQ-029 Instruction latencies with memready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-030 reset=1 SHALL set state=FETCH asynchronously, in any state including mid-wait in MEMRD/MEMWR.
REQ-031 During reset, outputs SHALL equal the FETCH decode with memready gating; no write strobe other than FETCH's gated irwrite/pcwrite may assert.
REQ-032 Reset deassertion SHALL be sampled synchronously; the first transition occurs on the first rising edge with reset=0.

Verification
REQ-033 Reset, memready=1, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-034 op=101011, memready low for 3 cycles in MEMWR -> state 5 held 4 cycles, memwrite=1 all 4, then state 0.
REQ-035 op=000100, zero=1 in BEQEX -> pcen=1, pcsrc=01, aluop=01; repeat with zero=0 -> pcen=0.
REQ-036 op=111111 -> DECODE asserts illegal=1 for one cycle, next state 0, no regwrite/memwrite.
REQ-037 Assert reset asynchronously mid-cycle in MEMRD -> state=0 before next edge; iord=0 immediately.
REQ-038 memready=0 in FETCH for 2 cycles -> irwrite=pcwrite=pcen=0 both cycles, state stays 0; memready=1 -> strobes 1, state 1 next.
